// File: rtl/dqt_parser.sv
// dqt_parser: finds DQT segments in a 32-bit big-endian JPEG word stream and
// writes each 8-bit quantisation table, in zig-zag order, to the quant RAM.
module dqt_parser #(
  parameter int unsigned NUM_TABLES = 4,
  parameter int unsigned ENTRIES    = 64,
  localparam int unsigned ID_W      = $clog2(NUM_TABLES),
  localparam int unsigned AW        = $clog2(ENTRIES)
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_enable,
  input  logic [31:0]           i_data_in,
  input  logic                  i_data_valid,
  output logic                  o_data_ready,
  output logic                  o_qt_we,
  output logic [ID_W-1:0]       o_qt_id,
  output logic [AW-1:0]         o_qt_addr,
  output logic [7:0]            o_qt_data,
  output logic                  o_table_done,
  output logic [NUM_TABLES-1:0] o_tables_loaded,
  output logic                  o_dqt_err
);

  typedef enum logic [2:0] {
    S_HUNT, S_MARK, S_LEN_HI, S_LEN_LO, S_PQTQ, S_ENTRY
  } state_t;

  state_t                r_state, w_state_nxt;
  logic [31:0]           r_buf;
  logic [2:0]            r_cnt;
  logic [7:0]            r_len_hi, w_len_hi_nxt;
  logic [15:0]           r_rem, w_rem_nxt;
  logic [AW-1:0]         r_idx, w_idx_nxt;
  logic [ID_W-1:0]       r_tq, w_tq_nxt;
  logic                  w_take, w_xfer, w_wr, w_err, w_last;
  logic [7:0]            w_byte;
  logic [15:0]           w_len;

  // Buffer can take a new word once it is down to its last byte.
  assign o_data_ready = i_enable && (r_cnt <= 3'd1);
  assign w_xfer       = i_data_valid && o_data_ready;
  assign w_take       = i_enable && (r_cnt != 3'd0);
  assign w_byte       = r_buf[31:24];
  assign w_len        = {r_len_hi, w_byte};

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_HUNT;
    else       r_state <= w_state_nxt;
  end

  // Next-state and per-byte decode; one byte is consumed per cycle.
  always_comb begin
    w_state_nxt  = r_state;
    w_len_hi_nxt = r_len_hi;
    w_rem_nxt    = r_rem;
    w_idx_nxt    = r_idx;
    w_tq_nxt     = r_tq;
    w_wr         = 1'b0;
    w_err        = 1'b0;
    w_last       = 1'b0;
    if (!i_enable) begin
      w_state_nxt = S_HUNT;
    end else if (w_take) begin
      case (r_state)
        S_HUNT:   if (w_byte == 8'hFF) w_state_nxt = S_MARK;
        S_MARK: begin
          if (w_byte == 8'hDB)      w_state_nxt = S_LEN_HI;
          else if (w_byte != 8'hFF) w_state_nxt = S_HUNT;
        end
        S_LEN_HI: begin
          w_len_hi_nxt = w_byte;
          w_state_nxt  = S_LEN_LO;
        end
        S_LEN_LO: begin
          w_rem_nxt = w_len - 16'd2;
          // Payload must be a whole number of 65-byte (Pq/Tq + 64) tables.
          if (w_len < 16'd67 || ((w_len - 16'd2) % 16'd65) != 16'd0) begin
            w_err       = 1'b1;
            w_state_nxt = S_HUNT;
          end else begin
            w_state_nxt = S_PQTQ;
          end
        end
        S_PQTQ: begin
          if (w_byte[7:4] != 4'd0 || 32'(w_byte[3:0]) >= NUM_TABLES) begin
            w_err       = 1'b1;
            w_state_nxt = S_HUNT;
          end else begin
            w_tq_nxt    = ID_W'(w_byte[3:0]);
            w_idx_nxt   = '0;
            w_rem_nxt   = r_rem - 16'd1;
            w_state_nxt = S_ENTRY;
          end
        end
        S_ENTRY: begin
          w_wr      = 1'b1;
          w_rem_nxt = r_rem - 16'd1;
          w_idx_nxt = r_idx + AW'(1);
          if (r_idx == AW'(ENTRIES - 1)) begin
            w_last      = 1'b1;
            w_state_nxt = (w_rem_nxt != 16'd0) ? S_PQTQ : S_HUNT;
          end
        end
        default: w_state_nxt = S_HUNT;
      endcase
    end
  end

  // Byte buffer: load on transfer, otherwise shift out one byte per cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst || !i_enable) begin
      r_buf <= '0;
      r_cnt <= 3'd0;
    end else if (w_xfer) begin
      r_buf <= i_data_in;
      r_cnt <= 3'd4;
    end else if (w_take) begin
      r_buf <= {r_buf[23:0], 8'h00};
      r_cnt <= r_cnt - 3'd1;
    end
  end

  // Segment bookkeeping: length high byte, remaining bytes, entry index, slot.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_len_hi <= '0;
      r_rem    <= '0;
      r_idx    <= '0;
      r_tq     <= '0;
    end else begin
      r_len_hi <= w_len_hi_nxt;
      r_rem    <= w_rem_nxt;
      r_idx    <= w_idx_nxt;
      r_tq     <= w_tq_nxt;
    end
  end

  // Registered write port, completion and error pulses; data fields zero when idle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_qt_we         <= 1'b0;
      o_qt_id         <= '0;
      o_qt_addr       <= '0;
      o_qt_data       <= '0;
      o_table_done    <= 1'b0;
      o_dqt_err       <= 1'b0;
      o_tables_loaded <= '0;
    end else begin
      o_qt_we      <= w_wr;
      o_qt_id      <= w_wr ? r_tq   : '0;
      o_qt_addr    <= w_wr ? r_idx  : '0;
      o_qt_data    <= w_wr ? w_byte : 8'h00;
      o_table_done <= w_last;
      o_dqt_err    <= w_err;
      if (w_last) o_tables_loaded <= o_tables_loaded | (NUM_TABLES'(1) << r_tq);
    end
  end

endmodule
